// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers for the width-converting FIFO family.
package fifo_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ratio_of(input int iw, input int ow);
    return iw / ow;
  endfunction
  function automatic int count_width(input int depth, input int iw, input int ow);
    return depth + clog2(iw / ow) + 1;
  endfunction
endpackage

// File: rtl/simple_dual_port_dist_ram.sv
// simple_dual_port_dist_ram: one synchronous write port, one asynchronous read port.
module simple_dual_port_dist_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [DEPTH-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [2**DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ratio_fifo.sv
// ratio_fifo: FWFT FIFO taking IN_WIDTH words and emitting RATIO OUT_WIDTH sub-words each,
// with exact output-word occupancy, sticky overflow/underflow and synchronous flush.
module ratio_fifo
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH           = 8,
  parameter int OUT_WIDTH          = 4,
  parameter int DEPTH              = 6,
  parameter int ALMOST_EMPTY_COUNT = 1,
  parameter int ALMOST_FULL_COUNT  = 1,
  parameter bit LSB_FIRST          = 1
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             flush,
  input  logic                                             push,
  input  logic [IN_WIDTH-1:0]                              d,
  input  logic                                             pop,
  output logic [OUT_WIDTH-1:0]                             q,
  output logic                                             empty,
  output logic                                             full,
  output logic [count_width(DEPTH, IN_WIDTH, OUT_WIDTH)-1:0] count,
  output logic                                             almost_empty,
  output logic                                             almost_full,
  output logic                                             overflow,
  output logic                                             underflow
);
  localparam int RATIO = ratio_of(IN_WIDTH, OUT_WIDTH);
  localparam int SW    = clog2(RATIO);
  localparam int CW    = count_width(DEPTH, IN_WIDTH, OUT_WIDTH);
  logic [DEPTH:0]      wr_ptr_q, wr_ptr_d, head, used;
  logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d, unf_q, unf_d, push_ok, pop_ok;
  logic [IN_WIDTH-1:0] rdata;
  // A partially drained head entry still occupies its slot until its last sub-word leaves.
  always_comb begin
    head         = rd_ptr_q[CW-1:SW];
    used         = wr_ptr_q - head;
    count        = (CW'(wr_ptr_q) << SW) - rd_ptr_q;
    empty        = count == '0;
    full         = used == (DEPTH+1)'(2**DEPTH);
    almost_empty = int'(count) <= ALMOST_EMPTY_COUNT;
    almost_full  = (2**DEPTH - int'(used)) <= ALMOST_FULL_COUNT;
    push_ok      = push && !full && !flush;
    pop_ok       = pop && !empty && !flush;
    wr_ptr_d     = flush ? '0 : wr_ptr_q + (DEPTH+1)'(push_ok);
    rd_ptr_d     = flush ? '0 : rd_ptr_q + CW'(pop_ok);
    ovf_d        = !flush && (ovf_q || (push && full));
    unf_d        = !flush && (unf_q || (pop && empty));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  simple_dual_port_dist_ram #(.WIDTH(IN_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q[DEPTH-1:0]),
    .wdata_i (d),
    .raddr_i (head[DEPTH-1:0]),
    .rdata_o (rdata)
  );
  if (RATIO == 1) begin : g_direct
    assign q = rdata;
  end else begin : g_mux
    logic [SW-1:0] sel;
    assign sel = LSB_FIRST ? rd_ptr_q[SW-1:0] : SW'(RATIO-1) - rd_ptr_q[SW-1:0];
    assign q   = rdata[sel*OUT_WIDTH +: OUT_WIDTH];
  end
endmodule
